// File: rtl/fu_result_pager_pkg.sv
// rtl/fu_result_pager_pkg.sv - shared encodings for the result pager and its board top level
package fu_result_pager_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  localparam int LED_V = 4;
  localparam int LED_C = 5;
  localparam int LED_N = 6;
  localparam int LED_Z = 7;

  function automatic int nib_count(input int word_size);
    return word_size / 4;
  endfunction

endpackage

// File: rtl/fu_result_pager_btn.sv
// rtl/fu_result_pager_btn.sv - btn_edge_db: shift-register debouncer with single rising-edge pulse
module btn_edge_db #(
  parameter int db_Len = 7
) (
  input  logic uclk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  logic [db_Len-1:0] shift_q;
  logic [db_Len-1:0] shift_d;
  logic              old_q;

  generate
    if (db_Len > 1) begin : g_shift
      assign shift_d = {shift_q[db_Len-2:0], raw};
    end else begin : g_single
      assign shift_d = raw;
    end
  endgenerate

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      old_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      old_q   <= level;
    end
  end

  // Level needs db_Len consecutive high samples; pulse fires once per settled press.
  assign level      = &shift_q;
  assign rise_pulse = level & ~old_q;

endmodule

// File: rtl/fu_result_pager.sv
// rtl/fu_result_pager.sv - captures an FU result and flags, pages its nibbles onto an 8-bit LED bar
module fu_result_pager
  import fu_result_pager_pkg::*;
#(
  parameter int word_Size   = 32,
  parameter int page_Width  = 3,
  parameter int db_Len      = 7,
  parameter int scan_Cycles = 50000000
) (
  input  logic                  uclk,
  input  logic                  rst,
  input  logic                  cap_stb,
  input  logic [word_Size-1:0]  F,
  input  logic                  V,
  input  logic                  C,
  input  logic                  N,
  input  logic                  Z,
  input  logic                  page_btn,
  input  logic                  auto_en,
  output logic [7:0]            LED,
  output logic [page_Width-1:0] page,
  output logic                  valid
);

  localparam int                    NIB_COUNT = nib_count(word_Size);
  localparam logic [page_Width-1:0] LAST_PAGE = page_Width'(NIB_COUNT - 1);
  localparam int                    CNT_W     = $clog2(scan_Cycles);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(scan_Cycles - 1);

  state_e                  state_q, state_d;
  logic [word_Size-1:0]    res_q;
  logic                    v_q, c_q, n_q, z_q;
  logic [page_Width-1:0]   page_q, page_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    load;
  logic                    btn_pulse;
  logic [page_Width-1:0]   page_next;
  logic [3:0]              nib;
  logic [7:0]              led_c;

  btn_edge_db #(
    .db_Len(db_Len)
  ) u_btn (
    .uclk      (uclk),
    .rst       (rst),
    .raw       (page_btn),
    .level     (),
    .rise_pulse(btn_pulse)
  );

  assign page_next = (page_q == LAST_PAGE) ? '0 : page_q + page_Width'(1);

  // Priority: capture, then button, then scan expiry; at most one page update per edge.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        page_d = '0;
        cnt_d  = '0;
        if (cap_stb) begin
          state_d = ST_SHOW;
          load    = 1'b1;
        end
      end
      ST_SHOW: begin
        if (cap_stb) begin
          load   = 1'b1;
          page_d = '0;
          cnt_d  = '0;
        end else if (btn_pulse) begin
          page_d = page_next;
          cnt_d  = '0;
        end else if (auto_en) begin
          if (cnt_q == CNT_LAST) begin
            page_d = page_next;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      page_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      v_q   <= 1'b0;
      c_q   <= 1'b0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
    end else if (load) begin
      res_q <= F;
      v_q   <= V;
      c_q   <= C;
      n_q   <= N;
      z_q   <= Z;
    end
  end

  assign nib = 4'(res_q >> {page_q, 2'b00});

  always_comb begin
    led_c = '0;
    if (state_q == ST_SHOW) begin
      led_c[3:0]   = nib;
      led_c[LED_V] = v_q;
      led_c[LED_C] = c_q;
      led_c[LED_N] = n_q;
      led_c[LED_Z] = z_q;
    end
  end

  assign LED   = led_c;
  assign page  = page_q;
  assign valid = (state_q == ST_SHOW);

endmodule

// File: tb/tb_fu_result_pager.sv
// tb/tb_fu_result_pager.sv - self-checking bench for fu_result_pager (db_Len=3, scan_Cycles=4)
module tb_fu_result_pager;

  logic        uclk = 1'b0;
  logic        rst;
  logic        cap_stb;
  logic [31:0] F;
  logic        V, C, N, Z;
  logic        page_btn;
  logic        auto_en;
  logic [7:0]  LED;
  logic [2:0]  page;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 uclk = ~uclk;

  fu_result_pager #(
    .word_Size  (32),
    .page_Width (3),
    .db_Len     (3),
    .scan_Cycles(4)
  ) dut (
    .uclk    (uclk),
    .rst     (rst),
    .cap_stb (cap_stb),
    .F       (F),
    .V       (V),
    .C       (C),
    .N       (N),
    .Z       (Z),
    .page_btn(page_btn),
    .auto_en (auto_en),
    .LED     (LED),
    .page    (page),
    .valid   (valid)
  );

  typedef struct {
    logic [7:0] led;
    logic [2:0] page;
    logic       valid;
  } exp_t;

  typedef struct {
    logic [31:0] f;
    logic        v, c, n, z;
    logic [7:0]  led;
  } cap_vec_t;

  exp_t sb_q[$];

  bit          m_show;
  logic [31:0] m_res;
  logic [3:0]  m_flg;
  int          m_page;
  int          m_cnt;
  logic [2:0]  m_sh;
  bit          m_old;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_show = 0; m_res = '0; m_flg = '0; m_page = 0; m_cnt = 0; m_sh = '0; m_old = 0;
    sb_q.delete();
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.led   = m_show ? {m_flg, m_res[4*m_page +: 4]} : 8'h00;
    e.page  = 3'(m_page);
    e.valid = m_show;
    return e;
  endfunction

  // Advance the reference model by one edge, push its prediction, then compare after the edge.
  task automatic tick();
    bit   lvl, pul;
    exp_t e;
    lvl = &m_sh;
    pul = lvl & ~m_old;
    if (!m_show) begin
      if (cap_stb) begin
        m_show = 1; m_res = F; m_flg = {Z, N, C, V}; m_page = 0; m_cnt = 0;
      end
    end else if (cap_stb) begin
      m_res = F; m_flg = {Z, N, C, V}; m_page = 0; m_cnt = 0;
    end else if (pul) begin
      m_page = (m_page + 1) % 8; m_cnt = 0;
    end else if (auto_en) begin
      if (m_cnt == 3) begin
        m_page = (m_page + 1) % 8; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
    end
    m_sh  = {m_sh[1:0], page_btn};
    m_old = lvl;
    sb_q.push_back(model_out());
    @(posedge uclk);
    #1;
    e = sb_q.pop_front();
    chk("cyc_led", 32'(LED), 32'(e.led));
    chk("cyc_page", 32'(page), 32'(e.page));
    chk("cyc_valid", 32'(valid), 32'(e.valid));
  endtask

  task automatic press(input int n);
    page_btn = 1'b1;
    repeat (n) tick();
    page_btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic capture(input cap_vec_t cv);
    F = cv.f; V = cv.v; C = cv.c; N = cv.n; Z = cv.z;
    cap_stb = 1'b1;
    tick();
    cap_stb = 1'b0;
  endtask

  cap_vec_t caps[5];
  logic [3:0] step_nib[8];
  int p0;
  int p;

  initial begin
    caps[0] = '{32'h8765_4321, 1'b1, 1'b0, 1'b1, 1'b0, 8'h51};
    caps[1] = '{32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAF};
    caps[2] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80};
    caps[3] = '{32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hF0};
    caps[4] = '{32'h8765_4321, 1'b1, 1'b0, 1'b1, 1'b0, 8'h51};
    step_nib = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h1};

    rst = 1'b1; cap_stb = 1'b0; F = '0; V = 0; C = 0; N = 0; Z = 0;
    page_btn = 1'b0; auto_en = 1'b0;
    model_reset();
    #1;
    chk("rst_led", 32'(LED), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    repeat (2) @(posedge uclk);
    #1;
    rst = 1'b0;

    // IDLE ignores buttons and auto_en
    auto_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      page_btn = ((i % 8) < 4);
      tick();
    end
    page_btn = 1'b0;
    auto_en  = 1'b0;
    repeat (3) tick();
    chk("idle_led", 32'(LED), 32'h00);
    chk("idle_page", 32'(page), 32'h0);
    chk("idle_valid", 32'(valid), 32'h0);

    // Capture table, including recapture while showing
    for (int i = 0; i < 5; i++) begin
      capture(caps[i]);
      chk("cap_led", 32'(LED), 32'(caps[i].led));
      chk("cap_page", 32'(page), 32'h0);
      chk("cap_valid", 32'(valid), 32'h1);
      F = $urandom; V = ~V; Z = ~Z;
      tick();
      chk("hold_led", 32'(LED), 32'(caps[i].led));
    end

    // Manual paging with wrap
    for (int i = 0; i < 8; i++) begin
      press(3);
      chk("btn_nib", 32'(LED[3:0]), 32'(step_nib[i]));
      chk("btn_page", 32'(page), 32'((i + 1) % 8));
    end
    press(2);
    chk("glitch_page", 32'(page), 32'h0);
    press(50);
    chk("hold_page", 32'(page), 32'h1);
    chk("hold_nib", 32'(LED[3:0]), 32'h2);

    // Auto-scan every 4 cycles, wrapping
    p0 = 1;
    auto_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      repeat (4) tick();
      chk("auto_page", 32'(page), 32'((p0 + k + 1) % 8));
    end
    repeat (2) tick();
    auto_en = 1'b0;
    p = (p0 + 8) % 8;
    repeat (10) tick();
    chk("auto_off_page", 32'(page), 32'(p));
    auto_en = 1'b1;
    repeat (3) tick();
    chk("auto_clr_page", 32'(page), 32'(p));
    tick();
    chk("auto_resume", 32'(page), 32'((p + 1) % 8));
    auto_en = 1'b0;
    tick();

    // Button pulse coincident with capture at page 5
    capture(caps[0]);
    repeat (5) press(3);
    chk("pre_sim_led", 32'(LED), 32'h56);
    page_btn = 1'b1;
    repeat (3) tick();
    capture('{32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08});
    chk("sim_page", 32'(page), 32'h0);
    chk("sim_led", 32'(LED), 32'h08);
    page_btn = 1'b0;
    repeat (4) tick();
    chk("sim_after_page", 32'(page), 32'h0);
    chk("sim_after_led", 32'(LED), 32'h08);

    // Asynchronous reset mid-scan
    auto_en = 1'b1;
    repeat (6) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_led", 32'(LED), 32'h00);
    chk("arst_page", 32'(page), 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    model_reset();
    #2;
    rst = 1'b0;
    press(3);
    repeat (10) tick();
    chk("post_rst_led", 32'(LED), 32'h00);
    chk("post_rst_valid", 32'(valid), 32'h0);
    auto_en = 1'b0;
    capture(caps[0]);
    chk("post_rst_cap", 32'(LED), 32'h51);
    chk("post_rst_vld", 32'(valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
